// File: rtl/snake_pkg.sv
// Shared game package: grid geometry, grid/position types, the grid2pos FSM
// state encoding, and the cell lookup that maps a linear position to its bit.
// Position p lives in row p/16 with column 0 held in the MSB of each row word.
package snake_pkg;

    localparam int GRID_DIM = 16;   // cells per row and per column
    localparam int POS_W    = 8;    // log2(GRID_DIM*GRID_DIM)
    localparam int CNT_W    = 9;    // wide enough to hold GRID_DIM*GRID_DIM
    localparam int COL_W    = 4;    // log2(GRID_DIM)

    typedef logic [GRID_DIM-1:0][GRID_DIM-1:0] grid_t;
    typedef logic [POS_W-1:0]                  pos_t;
    typedef logic [CNT_W-1:0]                  cnt_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        EMIT,
        DONE
    } g2p_state_t;

    // Column 0 is the MSB of a row, hence the reversal on the low index bits.
    function automatic logic cell_at(input grid_t g, input pos_t p);
        return g[p[POS_W-1:COL_W]][COL_W'(GRID_DIM-1) - p[COL_W-1:0]];
    endfunction

endpackage

// File: rtl/grid2pos.sv
// Scans a snapshot of a 16x16 occupancy bitmap and streams the index of every set cell.
// Latency: start -> first cell examined next cycle; one cycle per cell plus one EMIT cycle per hit.
// Backpressure: pos is held in EMIT until pos_ready; the scan pauses, nothing is dropped or repeated.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   start               one-cycle request to snapshot grid and scan (ignored unless idle)
//   grid                occupancy bitmap, cell p at grid[p>>4][15-(p%16)]
//   pos_valid/pos_ready position stream handshake; pos = row*16 + col
//   busy                high while scanning or emitting
//   done                one-cycle pulse when the scan finishes; count is then valid
//   count               number of set cells found in the last completed scan
module grid2pos
    import snake_pkg::*;
(
    input  logic  clk,
    input  logic  reset_n,
    input  logic  start,
    input  grid_t grid,
    input  logic  pos_ready,
    output logic  pos_valid,
    output pos_t  pos,
    output logic  busy,
    output logic  done,
    output cnt_t  count
);

    localparam pos_t POS_LAST = pos_t'(GRID_DIM*GRID_DIM - 1);

    g2p_state_t state;
    grid_t      snap;
    pos_t       idx;

    // All outputs are registered alongside the state so pos_valid, busy and
    // done are decided one cycle ahead and never see pos_ready combinationally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            snap      <= '0;
            idx       <= '0;
            pos       <= '0;
            count     <= '0;
            pos_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        snap  <= grid;
                        idx   <= '0;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= SCAN;
                    end
                end

                SCAN: begin
                    if (cell_at(snap, idx)) begin
                        pos       <= idx;
                        count     <= count + 1'b1;
                        pos_valid <= 1'b1;
                        state     <= EMIT;
                    end else if (idx == POS_LAST) begin
                        // Explicit end test: idx must not wrap back to 0.
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end

                EMIT: begin
                    if (pos_ready) begin
                        pos_valid <= 1'b0;
                        if (idx == POS_LAST) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= SCAN;
                        end
                    end
                end

                DONE: begin
                    // start is deliberately not sampled here.
                    state <= IDLE;
                end

                default: begin
                    state     <= IDLE;
                    pos_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_grid2pos.sv
// Directed bench for grid2pos: hand-built grids with hand-computed positions,
// counts and done cycles (done lands at cycle 257 + hits + stall cycles after start).
module tb_grid2pos;
    import snake_pkg::*;

    logic  clk;
    logic  reset_n;
    logic  start;
    grid_t grid;
    logic  pos_ready;
    logic  pos_valid;
    pos_t  pos;
    logic  busy;
    logic  done;
    cnt_t  count;

    int n_checks;
    int n_fail;
    int got_q[$];

    grid2pos dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .grid      (grid),
        .pos_ready (pos_ready),
        .pos_valid (pos_valid),
        .pos       (pos),
        .busy      (busy),
        .done      (done),
        .count     (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic grid_t with_cell(input grid_t g, input int p);
        grid_t r;
        r = g;
        r[p / 16][15 - (p % 16)] = 1'b1;
        return r;
    endfunction

    // Presents g with start high across one rising edge (edge k).
    task automatic do_start(input grid_t g);
        grid  = g;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Observes the scan from cycle 1 (first SCAN cycle) until done. Each pending
    // item is refused for `stall` cycles before being accepted. At cycle mut_cyc
    // the grid input is replaced and start is pulsed again.
    task automatic run_scan(input string name, input int stall, input int mut_cyc,
                            input grid_t mut_grid, input int budget,
                            output int done_cyc, output int busy_cyc,
                            output int vld_cyc, output int unstable);
        int   vld_seen;
        logic prev_hold;
        pos_t prev_pos;
        got_q.delete();
        done_cyc  = -1;
        busy_cyc  = 0;
        vld_cyc   = 0;
        unstable  = 0;
        vld_seen  = 0;
        prev_hold = 1'b0;
        prev_pos  = '0;
        for (int c = 1; c <= budget; c++) begin
            if (done) begin
                done_cyc = c;
                break;
            end
            if (busy) busy_cyc++;
            start = (c == mut_cyc);
            if (c == mut_cyc) grid = mut_grid;
            if (pos_valid) begin
                vld_cyc++;
                vld_seen++;
                if (prev_hold && pos != prev_pos) unstable++;
                pos_ready = (vld_seen > stall);
                if (pos_ready) begin
                    got_q.push_back(int'(pos));
                    vld_seen = 0;
                end
                prev_hold = !pos_ready;
                prev_pos  = pos;
            end else begin
                pos_ready = (stall == 0);
                prev_hold = 1'b0;
            end
            step();
        end
        start = 1'b0;
        check({name, " done seen"}, 32'(done_cyc > 0), 1);
        if (done_cyc > 0) begin
            check({name, " busy low with done"}, 32'(busy), 0);
            step();
            check({name, " done one cycle"}, 32'(done), 0);
        end
    endtask

    initial begin
        int    dc, bc, vc, un, errs, pulses;
        grid_t g;

        n_checks  = 0;
        n_fail    = 0;
        start     = 1'b0;
        grid      = '0;
        pos_ready = 1'b1;
        reset_n   = 1'b1;
        #3 reset_n = 1'b0;
        #1;
        check("reset pos_valid", 32'(pos_valid), 0);
        check("reset pos", 32'(pos), 0);
        check("reset busy", 32'(busy), 0);
        check("reset done", 32'(done), 0);
        check("reset count", 32'(count), 0);
        step();
        step();
        reset_n = 1'b1;
        step();

        // Empty grid: no output, busy for 256 cycles, done at k+257.
        do_start('0);
        run_scan("empty", 0, 0, '0, 400, dc, bc, vc, un);
        check("empty done cycle", 32'(dc), 257);
        check("empty busy cycles", 32'(bc), 256);
        check("empty valid cycles", 32'(vc), 0);
        check("empty count", 32'(count), 0);

        // First and last cell only.
        g = '0;
        g[0][15] = 1'b1;
        g[15][0] = 1'b1;
        pos_ready = 1'b1;
        do_start(g);
        run_scan("corners", 0, 0, '0, 400, dc, bc, vc, un);
        check("corners n", 32'(got_q.size()), 2);
        if (got_q.size() == 2) begin
            check("corners first", 32'(got_q[0]), 0);
            check("corners second", 32'(got_q[1]), 255);
        end
        check("corners count", 32'(count), 2);
        check("corners done cycle", 32'(dc), 259);

        // Single cell 0x23 with five refused cycles before acceptance.
        g = with_cell('0, 'h23);
        pos_ready = 1'b0;
        do_start(g);
        run_scan("stall", 5, 0, '0, 400, dc, bc, vc, un);
        check("stall n", 32'(got_q.size()), 1);
        if (got_q.size() == 1) check("stall pos", 32'(got_q[0]), 'h23);
        check("stall valid cycles", 32'(vc), 6);
        check("stall pos stable", 32'(un), 0);
        check("stall count", 32'(count), 1);
        check("stall done cycle", 32'(dc), 263);

        // Grid change and a second start mid-scan must not disturb the snapshot.
        g = with_cell('0, 'h10);
        pos_ready = 1'b1;
        do_start(g);
        run_scan("snapshot", 0, 40, with_cell(g, 'h80), 400, dc, bc, vc, un);
        check("snapshot n", 32'(got_q.size()), 1);
        if (got_q.size() == 1) check("snapshot pos", 32'(got_q[0]), 'h10);
        check("snapshot count", 32'(count), 1);
        check("snapshot done cycle", 32'(dc), 258);
        check("snapshot idle after", 32'(busy), 0);

        // Full grid: every index in order, count 256.
        pos_ready = 1'b1;
        do_start('1);
        run_scan("full", 0, 0, '0, 700, dc, bc, vc, un);
        check("full n", 32'(got_q.size()), 256);
        errs = 0;
        foreach (got_q[i]) if (got_q[i] != i) errs++;
        check("full order errors", 32'(errs), 0);
        check("full count", 32'(count), 256);
        check("full done cycle", 32'(dc), 513);

        // Reset while an item is held in EMIT.
        pos_ready = 1'b0;
        do_start(with_cell('0, 'h23));
        for (int c = 0; c < 100 && !pos_valid; c++) step();
        check("rst reached emit", 32'(pos_valid), 1);
        reset_n = 1'b0;
        #2;
        check("rst pos_valid", 32'(pos_valid), 0);
        check("rst pos", 32'(pos), 0);
        check("rst busy", 32'(busy), 0);
        check("rst done", 32'(done), 0);
        check("rst count", 32'(count), 0);
        step();
        reset_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            if (done || busy || pos_valid) pulses++;
            step();
        end
        check("rst quiet after", 32'(pulses), 0);
        pos_ready = 1'b1;
        do_start(with_cell('0, 'h23));
        run_scan("after rst", 0, 0, '0, 400, dc, bc, vc, un);
        check("after rst n", 32'(got_q.size()), 1);
        if (got_q.size() == 1) check("after rst pos", 32'(got_q[0]), 'h23);
        check("after rst count", 32'(count), 1);
        check("after rst done cycle", 32'(dc), 258);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
